tcam_update_ctrl: RTL

TCAM_UPDATE_CTRL -- requirements
Module: tcam_update_ctrl

---
 rtl/fractcam_pkg.sv | 16 +
 rtl/tcam_update_ctrl_srl_bit_gen.sv | 20 ++
 rtl/tcam_update_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fractcam_pkg.sv
// Shared sizing constants and FSM state encoding for the fractured-TCAM update path.
package fractcam_pkg;

    localparam int CHUNK_W   = 5;
    localparam int NUM_CHUNK = 6;
    localparam int NUM_BLOCK = 8;
    localparam int SRL_DEPTH = 32;
    localparam int KEY_W     = CHUNK_W * NUM_CHUNK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/tcam_update_ctrl_srl_bit_gen.sv
// Match bit for one key chunk at one SRL address; purely combinational.
module srl_bit_gen
    import fractcam_pkg::*;
#(
    parameter int CW = CHUNK_W
) (
    input  logic [CW-1:0] k,
    input  logic [CW-1:0] key_c,
    input  logic [CW-1:0] mask_c,
    input  logic          del,
    output logic          match
);

    // Shift order starts at the top address: with depth 2**CW, (depth-1-k) is ~k.
    logic [CW-1:0] srl_addr;

    assign srl_addr = ~k;
    assign match    = !del && ((srl_addr & ~mask_c) == (key_c & ~mask_c));

endmodule

// File: rtl/tcam_update_ctrl.sv
// Serialises one rule write into a block of SRL-based TCAM chunks: 32 shift cycles plus a done cycle.
// All outputs are registered from next-state values, so they change on the edge the state changes.
module tcam_update_ctrl #(
    parameter int  CHUNK_W   = fractcam_pkg::CHUNK_W,
    parameter int  NUM_CHUNK = fractcam_pkg::NUM_CHUNK,
    parameter int  NUM_BLOCK = fractcam_pkg::NUM_BLOCK,
    parameter int  SRL_DEPTH = fractcam_pkg::SRL_DEPTH,
    localparam int KEY_W     = CHUNK_W * NUM_CHUNK,
    localparam int ADDR_W    = $clog2(NUM_BLOCK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [KEY_W-1:0]     wr_key,
    input  logic [KEY_W-1:0]     wr_mask,
    input  logic                 wr_del,
    output logic [NUM_BLOCK-1:0] ce_demux,
    output logic                 flag,
    output logic                 wr_in,
    output logic [NUM_CHUNK-1:0] srl_din,
    output logic                 busy,
    output logic                 done
);

    import fractcam_pkg::*;

    localparam logic [CHUNK_W-1:0] K_LAST = CHUNK_W'(SRL_DEPTH - 1);

    state_t               state, state_nxt;
    logic [CHUNK_W-1:0]   k, k_nxt;
    logic [ADDR_W-1:0]    addr_q, addr_nxt;
    logic [KEY_W-1:0]     key_q, key_nxt;
    logic [KEY_W-1:0]     mask_q, mask_nxt;
    logic                 del_q, del_nxt;

    logic [NUM_CHUNK-1:0] match_nxt;
    logic [NUM_BLOCK-1:0] ce_demux_nxt;
    logic [NUM_CHUNK-1:0] srl_din_nxt;
    logic                 wr_ready_nxt, busy_nxt, flag_nxt, wr_in_nxt, done_nxt;

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        addr_nxt  = addr_q;
        key_nxt   = key_q;
        mask_nxt  = mask_q;
        del_nxt   = del_q;
        case (state)
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    addr_nxt  = wr_addr;
                    key_nxt   = wr_key;
                    mask_nxt  = wr_mask;
                    del_nxt   = wr_del;
                    k_nxt     = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                k_nxt = k + CHUNK_W'(1);
                if (k == K_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Match bits are evaluated on next-state values so srl_din lines up with the registered strobes.
    for (genvar c = 0; c < NUM_CHUNK; c++) begin : g_chunk
        srl_bit_gen #(.CW(CHUNK_W)) u_srl_bit_gen (
            .k      (k_nxt),
            .key_c  (key_nxt[c*CHUNK_W +: CHUNK_W]),
            .mask_c (mask_nxt[c*CHUNK_W +: CHUNK_W]),
            .del    (del_nxt),
            .match  (match_nxt[c])
        );
    end

    always_comb begin
        wr_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt != IDLE);
        flag_nxt     = (state_nxt == SHIFT);
        wr_in_nxt    = (state_nxt == SHIFT);
        done_nxt     = (state_nxt == DONE);
        ce_demux_nxt = '0;
        srl_din_nxt  = '0;
        if (state_nxt == SHIFT) begin
            ce_demux_nxt = NUM_BLOCK'(1) << addr_nxt;
            srl_din_nxt  = match_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            addr_q   <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            del_q    <= 1'b0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            flag     <= 1'b0;
            wr_in    <= 1'b0;
            done     <= 1'b0;
            ce_demux <= '0;
            srl_din  <= '0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            addr_q   <= addr_nxt;
            key_q    <= key_nxt;
            mask_q   <= mask_nxt;
            del_q    <= del_nxt;
            wr_ready <= wr_ready_nxt;
            busy     <= busy_nxt;
            flag     <= flag_nxt;
            wr_in    <= wr_in_nxt;
            done     <= done_nxt;
            ce_demux <= ce_demux_nxt;
            srl_din  <= srl_din_nxt;
        end
    end

endmodule
